// File: rtl/lk_acc_irq_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : lk_acc_irq_sequencer_if
// Brief   : AXI4-Lite bus bundle between the LK IRQ sequencer and the
//           peripheral interconnect.
// Rev     : 1.0  initial release
// ============================================================================
interface lk_acc_irq_sequencer_if #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64
);
    logic [ADDR_BITS-1:0]   awaddr;
    logic [2:0]             awprot;
    logic                   awvalid;
    logic                   awready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [ADDR_BITS-1:0]   araddr;
    logic [2:0]             arprot;
    logic                   arvalid;
    logic                   arready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/lk_acc_irq_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : lk_acc_irq_sequencer
// Brief   : Services the LK accumulator IRQ in hardware: reads the sums,
//           hands them to the flow solver and writes the solved flow back.
// Rev     : 1.0  initial release
// ============================================================================
module lk_acc_irq_sequencer #(
    parameter int                   ADDR_BITS     = 40,
    parameter int                   DATA_BITS     = 64,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 40'ha041_0000,
    parameter int                   ACC_NUM       = 4,
    parameter logic [7:0]           REG_ACC_FIRST = 8'h40,
    parameter logic [7:0]           REG_ACC_READY = 8'h3c,
    parameter logic [7:0]           REG_IRQ_CLR   = 8'h0a,
    parameter logic [7:0]           REG_OUT_DX0   = 8'h60,
    parameter logic [7:0]           REG_OUT_DY0   = 8'h61,
    parameter logic [7:0]           REG_OUT_VALID = 8'h6f
) (
    input  wire logic                         aclk,
    input  wire logic                         aresetn,
    input  wire logic                         enable,
    input  wire logic                         irq,
    output logic                              busy,
    output logic                              bus_err,
    output logic [31:0]                       event_count,
    output logic [ACC_NUM*DATA_BITS-1:0]      m_acc_data,
    output logic                              m_acc_valid,
    input  wire logic                         m_acc_ready,
    input  wire logic [DATA_BITS-1:0]         s_flow_dx,
    input  wire logic [DATA_BITS-1:0]         s_flow_dy,
    input  wire logic                         s_flow_valid,
    output logic                              s_flow_ready,
    lk_acc_irq_sequencer_if.master            m_axi4l
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_RD_ACC    = 4'd1;
    localparam logic [3:0] c_SEND      = 4'd2;
    localparam logic [3:0] c_WR_READY  = 4'd3;
    localparam logic [3:0] c_WR_CLR    = 4'd4;
    localparam logic [3:0] c_WAIT_FLOW = 4'd5;
    localparam logic [3:0] c_WR_DX     = 4'd6;
    localparam logic [3:0] c_WR_DY     = 4'd7;
    localparam logic [3:0] c_WR_VALID  = 4'd8;

    localparam int               c_IDX_W    = (ACC_NUM > 1) ? $clog2(ACC_NUM) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(ACC_NUM - 1);

    logic [3:0]                 r_state;
    logic [c_IDX_W-1:0]         r_idx;
    logic [ACC_NUM*DATA_BITS-1:0] r_acc_data;
    logic                       r_acc_valid;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic [DATA_BITS-1:0]       r_dx;
    logic [DATA_BITS-1:0]       r_dy;
    logic                       r_bus_err;
    logic [31:0]                r_event_count;

    logic                       w_wr_state;
    logic                       w_bready;
    logic [7:0]                 w_wr_reg;
    logic [DATA_BITS-1:0]       w_wr_data;
    logic [3:0]                 w_wr_next;

    function automatic logic [ADDR_BITS-1:0] f_reg_addr(input logic [7:0] idx);
        return BASE_ADDR + (ADDR_BITS'(idx) * ADDR_BITS'(DATA_BITS / 8));
    endfunction

    always_comb begin
        w_wr_state = 1'b0;
        w_wr_reg   = REG_ACC_READY;
        w_wr_data  = DATA_BITS'(1);
        w_wr_next  = c_IDLE;
        case (r_state)
            c_WR_READY: begin
                w_wr_state = 1'b1;
                w_wr_next  = c_WR_CLR;
            end
            c_WR_CLR: begin
                w_wr_state = 1'b1;
                w_wr_reg   = REG_IRQ_CLR;
                w_wr_next  = c_WAIT_FLOW;
            end
            c_WR_DX: begin
                w_wr_state = 1'b1;
                w_wr_reg   = REG_OUT_DX0;
                w_wr_data  = r_dx;
                w_wr_next  = c_WR_DY;
            end
            c_WR_DY: begin
                w_wr_state = 1'b1;
                w_wr_reg   = REG_OUT_DY0;
                w_wr_data  = r_dy;
                w_wr_next  = c_WR_VALID;
            end
            c_WR_VALID: begin
                w_wr_state = 1'b1;
                w_wr_reg   = REG_OUT_VALID;
            end
            default: ;
        endcase
    end

    // Each valid is held until its own beat, so both low means both beats are done.
    assign w_bready = w_wr_state && !r_awvalid && !r_wvalid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state       <= c_IDLE;
            r_idx         <= '0;
            r_acc_data    <= '0;
            r_acc_valid   <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_dx          <= '0;
            r_dy          <= '0;
            r_bus_err     <= 1'b0;
            r_event_count <= '0;
        end else begin
            if ((r_rready && m_axi4l.rvalid && m_axi4l.rresp != 2'b00) ||
                (w_bready && m_axi4l.bvalid && m_axi4l.bresp != 2'b00))
                r_bus_err <= 1'b1;

            case (r_state)
                c_IDLE: begin
                    if (enable && irq) begin
                        r_state   <= c_RD_ACC;
                        r_idx     <= '0;
                        r_arvalid <= 1'b1;
                        r_rready  <= 1'b1;
                    end
                end
                c_RD_ACC: begin
                    if (r_arvalid && m_axi4l.arready)
                        r_arvalid <= 1'b0;
                    if (r_rready && m_axi4l.rvalid) begin
                        r_acc_data[int'(r_idx)*DATA_BITS +: DATA_BITS] <= m_axi4l.rdata;
                        if (r_idx == c_LAST_IDX) begin
                            r_state     <= c_SEND;
                            r_rready    <= 1'b0;
                            r_acc_valid <= 1'b1;
                        end else begin
                            r_idx     <= r_idx + 1'b1;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                c_SEND: begin
                    if (m_acc_ready) begin
                        r_acc_valid <= 1'b0;
                        r_state     <= c_WR_READY;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                    end
                end
                c_WAIT_FLOW: begin
                    if (s_flow_valid) begin
                        r_dx      <= s_flow_dx;
                        r_dy      <= s_flow_dy;
                        r_state   <= c_WR_DX;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                c_WR_READY, c_WR_CLR, c_WR_DX, c_WR_DY, c_WR_VALID: begin
                    if (r_awvalid && m_axi4l.awready)
                        r_awvalid <= 1'b0;
                    if (r_wvalid && m_axi4l.wready)
                        r_wvalid <= 1'b0;
                    if (w_bready && m_axi4l.bvalid) begin
                        r_state <= w_wr_next;
                        if (w_wr_next != c_WAIT_FLOW && w_wr_next != c_IDLE) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end
                        if (r_state == c_WR_VALID)
                            r_event_count <= r_event_count + 32'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign bus_err      = r_bus_err;
    assign event_count  = r_event_count;
    assign m_acc_data   = r_acc_data;
    assign m_acc_valid  = r_acc_valid;
    assign s_flow_ready = (r_state == c_WAIT_FLOW);

    assign m_axi4l.araddr  = f_reg_addr(REG_ACC_FIRST + 8'(r_idx));
    assign m_axi4l.arprot  = 3'b000;
    assign m_axi4l.arvalid = r_arvalid;
    assign m_axi4l.rready  = r_rready;
    assign m_axi4l.awaddr  = f_reg_addr(w_wr_reg);
    assign m_axi4l.awprot  = 3'b000;
    assign m_axi4l.awvalid = r_awvalid;
    assign m_axi4l.wdata   = w_wr_data;
    assign m_axi4l.wstrb   = '1;
    assign m_axi4l.wvalid  = r_wvalid;
    assign m_axi4l.bready  = w_bready;

endmodule
`default_nettype wire

// File: doc/lk_acc_irq_sequencer.md
Name: lk_acc_irq_sequencer

Overview:
- Hardware replacement for the software interrupt-service loop of the Lucas-Kanade accumulator (img_lk_acc).
- On the LK IRQ line it acts as an AXI4-Lite master on the peripheral bus:
  - reads the accumulator sum registers;
  - hands them to a downstream flow solver on a valid/ready port;
  - acknowledges the accumulator (ACC_READY, IRQ_CLR);
  - writes the solver's dx/dy result back (OUT_DX0, OUT_DY0, OUT_VALID).
- Sits beside the CPU as a second master on the peripheral AXI4-Lite interconnect.

Parameters:
- ADDR_BITS, 40, AXI4-Lite address width.
- DATA_BITS, 64, AXI4-Lite data width; also the width of every accumulator and flow word.
- BASE_ADDR, 40'ha041_0000, LK accumulator register block base address.
- ACC_NUM, 4, number of accumulator registers read per event; indices are contiguous.
- REG_ACC_FIRST, 8'h40, register index of the first accumulator (GXX0).
- REG_ACC_READY, 8'h3c, register index of ACC_READY.
- REG_IRQ_CLR, 8'h0a, register index of IRQ_CLR.
- REG_OUT_DX0, 8'h60, register index of OUT_DX0.
- REG_OUT_DY0, 8'h61, register index of OUT_DY0.
- REG_OUT_VALID, 8'h6f, register index of OUT_VALID.
- Byte address of register index k = BASE_ADDR + k*(DATA_BITS/8).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- enable  in  1  allow new sequences to start.
- irq  in  1  level IRQ from the LK accumulator.
- busy  out  1  high whenever state != IDLE.
- bus_err  out  1  sticky; set on any bresp/rresp != OKAY; cleared only by reset.
- event_count  out  32  completed sequences, wraps modulo 2^32.
- m_acc_data  out  ACC_NUM*DATA_BITS  accumulator words; word i occupies bits [i*DATA_BITS +: DATA_BITS].
- m_acc_valid  out  1  accumulator words valid.
- m_acc_ready  in  1  solver accepts m_acc_data.
- s_flow_dx  in  DATA_BITS  signed Q.13 dx.
- s_flow_dy  in  DATA_BITS  signed Q.13 dy.
- s_flow_valid  in  1  solver result valid.
- s_flow_ready  out  1  result accepted.
- m_axi4l_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite master, widths per ADDR_BITS/DATA_BITS.

Behaviour:
- Reset values (aresetn=0 at a rising aclk edge), in the same cycle:
  - all valid and ready outputs 0;
  - busy=0, bus_err=0, event_count=0, m_acc_data=0;
  - state=IDLE.
  - Reset mid-transaction drops valids immediately; the interconnect is reset by the same aresetn.
- Constant outputs: awprot=arprot=0; wstrb all ones.
- States: IDLE → RD_ACC → SEND → WR_READY → WR_CLR → WAIT_FLOW → WR_DX → WR_DY → WR_VALID → IDLE.
- IDLE:
  - Enter RD_ACC on the cycle after a clock edge sampling enable=1 and irq=1, with an index counter of 0.
  - Deasserting enable outside IDLE has no effect; the running sequence completes.
- RD_ACC, per index i:
  - Assert arvalid with araddr = addr(REG_ACC_FIRST+i).
  - Drop arvalid after the arvalid&arready beat.
  - Hold rready=1 until rvalid; capture rdata into word i.
  - After word ACC_NUM-1 go to SEND.
  - Exactly one outstanding transaction; AR for i+1 is never issued before R for i.
- SEND:
  - m_acc_valid=1 with stable data until m_acc_ready; transfer on valid&ready.
  - m_acc_valid must not depend combinationally on ready.
- Write states (WR_*):
  - awvalid and wvalid rise together; each drops independently after its own handshake.
  - bready=1 after both handshakes; the state completes on bvalid&bready.
  - WR_READY writes 1 to ACC_READY; WR_CLR writes 1 to IRQ_CLR.
- WAIT_FLOW:
  - s_flow_ready=1 only in this state.
  - On s_flow_valid&s_flow_ready, latch dx and dy, then go to WR_DX.
- WR_DX writes the latched dx to OUT_DX0; WR_DY writes the latched dy to OUT_DY0; WR_VALID writes 1 to OUT_VALID.
- Completion: on WR_VALID completion, event_count increments and state returns to IDLE. irq is re-evaluated on the next cycle, so the minimum idle gap is 1 cycle.
- Error responses: a non-OKAY rresp or bresp sets bus_err. The sequence continues with the returned data unchanged (no retry).
- irq is level-sampled only in IDLE; toggling irq during a sequence is ignored.
- Data path: no arithmetic on data; dx/dy pass bit-exact, with sign preserved by the full DATA_BITS width.

Test Plan:
- Reset, then irq=1, enable=1, slave returning rdata 10,11,12,13 → ARs at a0410200..a0410218 in order; m_acc_data words = {13,12,11,10}; busy=1 from the cycle after irq is sampled.
- Solver returns dx=8192*210, dy=-8192*123 → AW/W sequence is 8'h3c←1, 8'h0a←1, 8'h60←0x1A4000, 8'h61←0xFFFF_FFFF_FFF0_A000, 8'h6f←1; event_count=1; busy=0.
- Slave withholds awready by 5 cycles while wready is immediate → wvalid drops after its beat, awvalid holds, bready only after the AW beat; no duplicate write.
- m_acc_ready held low for 20 cycles → m_acc_valid and data stay stable; no AXI traffic in that window.
- enable=0 with irq=1 → no transactions. Deassert enable mid-sequence → the sequence completes, and no new one starts.
- Slave returns rresp=SLVERR on word 2 → bus_err=1 and persists; the sequence completes. Pulse aresetn low during WR_DY → all valids 0 next cycle, bus_err=0, event_count=0.
